hfosc_power_sequencer: RTL
==========================

Name: hfosc_power_sequencer

Overview:
Sequences the iCE40 high-frequency oscillator (HFOSC) power-up and enable pins on behalf of the processor core. It runs on the always-on low-frequency clock. It gates the HF clock only after a software sleep request and a quiet period with no memory stalls. It powers the oscillator fully down after a further idle delay, and restores it on any unmasked wake source, holding `hf_ready` low until the oscillator has settled.

Parameters:
- `NUM_WAKE`, default 4: number of wake-source inputs.
- `CNT_W`, default 8: width of the shared state counter.
- `SETTLE_CYCLES`, default 4: clk cycles from power-up to enable. Minimum 1.
- `QUIET_CYCLES`, default 2: consecutive non-busy cycles required before gating. Minimum 1.
- `OFF_DELAY`, default 8: cycles spent gated before powering down. Minimum 1.
- Constraint: every count parameter must be ≤ 2^`CNT_W`−1. A violation is fatal at elaboration.

Ports:
- `clk` input 1: always-on low-frequency clock (LFOSC domain).
- `rst_n` input 1: reset.
- `sleep_req` input 1: single-cycle request from the core to gate the HF clock.
- `busy` input 1: core/data-memory stall active (level); blocks gating.
- `wake_src` input `NUM_WAKE`: asynchronous level wake sources.
- `wake_mask` input `NUM_WAKE`: 1 = source enabled; synchronous to clk.
- `clkhf_powerup` output 1: drives HFOSC CLKHFPU.
- `clkhf_enable` output 1: drives HFOSC CLKHFEN.
- `hf_ready` output 1: HF clock stable and running.
- `pmu_state` output 3: current FSM state encoding.
- `wake_cause` output `NUM_WAKE`: sticky record of the sources that ended the last sleep.

Interface decision: one clock; reset is asynchronous and active-low. All outputs are registered.

Behaviour:
Reset values:
- state = PWRUP, cnt = 0.
- `clkhf_powerup` = 1, `clkhf_enable` = 0, `hf_ready` = 0, `wake_cause` = 0.

Wake path:
- `wake_src` passes through a 2-flop synchronizer to give `wake_s`.
- `wake_hit` = |(`wake_s` & `wake_mask`).
- Latency from a `wake_src` edge to `wake_hit` is 2 clk cycles.

States (codes 0–4), with outputs given as `clkhf_powerup`/`clkhf_enable`/`hf_ready`:
- OFF (outputs 0/0/0)
  - `wake_hit` → PWRUP, cnt = 0, `wake_cause` |= `wake_s` & `wake_mask`.
- PWRUP (outputs 1/0/0)
  - cnt increments each cycle.
  - When cnt == `SETTLE_CYCLES`−1 → RUN.
  - `clkhf_enable` rises exactly `SETTLE_CYCLES` cycles after PWRUP entry.
  - Wakes are ignored here (already powering up).
- RUN (outputs 1/1/1)
  - `sleep_req` with no `wake_hit` → DRAIN, cnt = 0, `wake_cause` cleared.
  - `sleep_req` in the same cycle as `wake_hit` is dropped; state stays RUN.
- DRAIN (outputs 1/1/1)
  - `busy` = 1 resets cnt to 0.
  - `busy` = 0 increments cnt.
  - When cnt reaches `QUIET_CYCLES`−1 with `busy` = 0 → GATE, cnt = 0.
  - `wake_hit` has priority: abort → RUN and record `wake_cause`.
  - `sleep_req` seen again while in DRAIN is ignored.
- GATE (outputs 1/0/0)
  - `wake_hit` → RUN next cycle. No settle delay, since the oscillator is still powered. Record `wake_cause`.
  - Otherwise cnt increments; at cnt == `OFF_DELAY`−1 → OFF.
  - If `wake_hit` and the final count occur in the same cycle, wake wins.

Counter rules:
- One shared cnt of `CNT_W` bits.
- Saturates and never wraps.
- Zeroed on every state change.

Other rules:
- `busy` is ignored outside DRAIN.
- Masked sources never wake the block, but still appear in `wake_s`.
- `rst_n` asserted in any state returns the block to the reset values immediately.
- Illegal state encodings recover to PWRUP.

Decomposition:
- Package `pmu_pkg` holds:
  - the state enum (OFF, PWRUP, RUN, DRAIN, GATE) with fixed 3-bit codes, exported on `pmu_state`;
  - the default timing constants.
- One sub-module, `wake_sync`: a `NUM_WAKE`-wide 2-flop synchronizer with async active-low reset to 0.
- The FSM, counter and cause register live in the top level.

Test Plan:
1. Reset release (defaults) → PWRUP for 4 cycles; `clkhf_enable` = 1 and `hf_ready` = 1 on cycle 4; `pmu_state` = RUN.
2. RUN, pulse `sleep_req`, `busy` = 0 → DRAIN for 2 cycles, then GATE (`clkhf_enable` = 0); after 8 more cycles OFF (`clkhf_powerup` = 0).
3. DRAIN with `busy` = 1,0,1,0,0 → stays in DRAIN until the two trailing zeros, then enters GATE. The counter restart is visible on `pmu_state`.
4. In GATE, assert `wake_src`[2] with mask 4'b0100 → RUN 2 cycles after the edge +1; `wake_cause` = 4'b0100; no PWRUP pass.
5. In OFF, `wake_src` = 4'b0011 with mask 4'b0001 → PWRUP, then RUN after 4 cycles; `wake_cause` = 4'b0001. With mask = 0, stays OFF indefinitely.
6. `sleep_req` and unmasked `wake_hit` in the same RUN cycle → remains RUN and `wake_cause` unchanged. Separately, assert `rst_n` low mid-GATE → immediately PWRUP with the reset output values.

Source files
------------

// File: rtl/pmu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pmu_pkg
//  Purpose  : Shared types and default timing constants for the HFOSC power
//             sequencer: the FSM state enum (codes exported on pmu_state),
//             the per-state HFOSC pin pattern, and a decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package pmu_pkg;

  // State codes are visible on pmu_state, so they are pinned explicitly.
  typedef enum logic [2:0] {
    PMU_OFF   = 3'd0,
    PMU_PWRUP = 3'd1,
    PMU_RUN   = 3'd2,
    PMU_DRAIN = 3'd3,
    PMU_GATE  = 3'd4
  } pmu_state_e;

  // Default timing constants (clk = always-on LF clock)
  localparam int C_NUM_WAKE_DEF  = 4;
  localparam int C_CNT_W_DEF     = 8;
  localparam int C_SETTLE_DEF    = 4;
  localparam int C_QUIET_DEF     = 2;
  localparam int C_OFF_DELAY_DEF = 8;

  // HFOSC pin pattern held in each state
  typedef struct packed {
    logic pu;   // CLKHFPU
    logic en;   // CLKHFEN
    logic rdy;  // HF clock usable by the core
  } hfosc_out_t;

  function automatic hfosc_out_t state_outputs(input pmu_state_e s);
    hfosc_out_t o;
    o = '{pu: 1'b1, en: 1'b0, rdy: 1'b0};
    case (s)
      PMU_OFF:   o = '{pu: 1'b0, en: 1'b0, rdy: 1'b0};
      PMU_PWRUP: o = '{pu: 1'b1, en: 1'b0, rdy: 1'b0};
      PMU_RUN:   o = '{pu: 1'b1, en: 1'b1, rdy: 1'b1};
      PMU_DRAIN: o = '{pu: 1'b1, en: 1'b1, rdy: 1'b1};
      PMU_GATE:  o = '{pu: 1'b1, en: 1'b0, rdy: 1'b0};
      default:   o = '{pu: 1'b1, en: 1'b0, rdy: 1'b0};
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hfosc_power_sequencer_wake_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wake_sync
//  Purpose  : WIDTH-wide two-flop synchronizer bringing asynchronous wake
//             levels into the always-on clock domain.
//  Ports    : clk      - destination clock
//             rst_n    - asynchronous active-low reset (flops clear to 0)
//             i_async  - asynchronous level inputs
//             o_sync   - synchronized levels (2 clk cycles of latency)
//  Revision : 1.0 - initial release
// ============================================================================
module wake_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/hfosc_power_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hfosc_power_sequencer
//  Purpose  : Sequences iCE40 HFOSC CLKHFPU/CLKHFEN from the always-on LF
//             clock. Gates the HF clock after a sleep request plus a quiet
//             period, powers it down after a further idle delay, and brings
//             it back on any unmasked wake source.
//  Ports    : clk           - always-on LF clock
//             rst_n         - asynchronous active-low reset
//             sleep_req     - single-cycle request to gate the HF clock
//             busy          - core/memory stall, blocks gating while in DRAIN
//             wake_src      - asynchronous wake levels
//             wake_mask     - per-source enable (1 = can wake)
//             clkhf_powerup - to HFOSC CLKHFPU
//             clkhf_enable  - to HFOSC CLKHFEN
//             hf_ready      - HF clock stable and running
//             pmu_state     - current FSM state code
//             wake_cause    - sticky sources that ended the last sleep
//  Revision : 1.0 - initial release
// ============================================================================
module hfosc_power_sequencer
  import pmu_pkg::*;
#(
  parameter int NUM_WAKE      = C_NUM_WAKE_DEF,
  parameter int CNT_W         = C_CNT_W_DEF,
  parameter int SETTLE_CYCLES = C_SETTLE_DEF,
  parameter int QUIET_CYCLES  = C_QUIET_DEF,
  parameter int OFF_DELAY     = C_OFF_DELAY_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sleep_req,
  input  logic                busy,
  input  logic [NUM_WAKE-1:0] wake_src,
  input  logic [NUM_WAKE-1:0] wake_mask,
  output logic                clkhf_powerup,
  output logic                clkhf_enable,
  output logic                hf_ready,
  output logic [2:0]          pmu_state,
  output logic [NUM_WAKE-1:0] wake_cause
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  localparam longint C_CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (SETTLE_CYCLES < 1 || longint'(SETTLE_CYCLES) > C_CNT_MAX) begin : g_bad_settle
    $fatal(1, "SETTLE_CYCLES out of range for CNT_W");
  end
  if (QUIET_CYCLES < 1 || longint'(QUIET_CYCLES) > C_CNT_MAX) begin : g_bad_quiet
    $fatal(1, "QUIET_CYCLES out of range for CNT_W");
  end
  if (OFF_DELAY < 1 || longint'(OFF_DELAY) > C_CNT_MAX) begin : g_bad_off
    $fatal(1, "OFF_DELAY out of range for CNT_W");
  end

  // Terminal counts: each state lasts exactly N cycles, so compare to N-1.
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_OFF_LAST    = CNT_W'(OFF_DELAY - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Wake path
  // --------------------------------------------------------------------------
  logic [NUM_WAKE-1:0] w_wake_s;
  logic [NUM_WAKE-1:0] w_hit_bits;
  logic                w_wake_hit;

  wake_sync #(
    .WIDTH (NUM_WAKE)
  ) u_wake_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (wake_src),
    .o_sync  (w_wake_s)
  );

  // Masked sources still reach w_wake_s but never count as a hit.
  assign w_hit_bits = w_wake_s & wake_mask;
  assign w_wake_hit = |w_hit_bits;

  // --------------------------------------------------------------------------
  // FSM, shared counter and cause register
  // --------------------------------------------------------------------------
  pmu_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  hfosc_out_t          r_out;
  logic [NUM_WAKE-1:0] r_cause;

  // Saturating increment: the counter never wraps back to 0.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : (r_cnt + C_CNT_ONE);

  // Outputs are registered alongside the state: every transition loads the
  // pin pattern of the destination state in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PMU_PWRUP;
      r_cnt   <= '0;
      r_out   <= state_outputs(PMU_PWRUP);
      r_cause <= '0;
    end else begin
      case (r_state)
        PMU_OFF: begin
          if (w_wake_hit) begin
            r_state <= PMU_PWRUP;
            r_out   <= state_outputs(PMU_PWRUP);
            r_cnt   <= '0;
            r_cause <= r_cause | w_hit_bits;
          end
        end

        // Wakes are irrelevant here: the oscillator is already coming up.
        PMU_PWRUP: begin
          if (r_cnt == C_SETTLE_LAST) begin
            r_state <= PMU_RUN;
            r_out   <= state_outputs(PMU_RUN);
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // A sleep request colliding with a wake is dropped.
        PMU_RUN: begin
          if (sleep_req && !w_wake_hit) begin
            r_state <= PMU_DRAIN;
            r_out   <= state_outputs(PMU_DRAIN);
            r_cnt   <= '0;
            r_cause <= '0;
          end
        end

        // Count consecutive quiet cycles; any busy cycle restarts the count.
        PMU_DRAIN: begin
          if (w_wake_hit) begin
            r_state <= PMU_RUN;
            r_out   <= state_outputs(PMU_RUN);
            r_cnt   <= '0;
            r_cause <= r_cause | w_hit_bits;
          end else if (busy) begin
            r_cnt <= '0;
          end else if (r_cnt == C_QUIET_LAST) begin
            r_state <= PMU_GATE;
            r_out   <= state_outputs(PMU_GATE);
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // Oscillator still powered: a wake returns straight to RUN, and it
        // beats the final off-delay count.
        PMU_GATE: begin
          if (w_wake_hit) begin
            r_state <= PMU_RUN;
            r_out   <= state_outputs(PMU_RUN);
            r_cnt   <= '0;
            r_cause <= r_cause | w_hit_bits;
          end else if (r_cnt == C_OFF_LAST) begin
            r_state <= PMU_OFF;
            r_out   <= state_outputs(PMU_OFF);
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        // Unreachable encodings restart the power-up sequence.
        default: begin
          r_state <= PMU_PWRUP;
          r_out   <= state_outputs(PMU_PWRUP);
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign clkhf_powerup = r_out.pu;
  assign clkhf_enable  = r_out.en;
  assign hf_ready      = r_out.rdy;
  assign pmu_state     = r_state;
  assign wake_cause    = r_cause;

endmodule
`default_nettype wire
